// File: rtl/lr_deserial_sfr.sv
// Serial-in/parallel-out SFR: assembles SIZE bits MSB- or LSB-first, with a full/rd handshake.
// Optional trailing even-parity bit when LRSR_PARITY_EN is defined.
module lr_deserial_sfr #(
    parameter int SIZE  = 32,
    parameter int CNT_W = $clog2(SIZE + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_sin,
    input  logic             i_shift_en,
    input  logic             i_left,
    input  logic             i_rd,
    output logic [SIZE-1:0]  o_Q,
    output logic             o_full,
    output logic [CNT_W-1:0] o_bit_count,
    output logic             o_overrun,
    output logic             o_parity_err
);

    typedef enum logic [1:0] {S_EMPTY, S_FILL, S_PARITY, S_FULL} state_t;

    state_t           r_state;
    logic             r_mode;
    logic [SIZE-1:0]  r_q;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_overrun;
    logic             r_parity_err;

    function automatic logic [SIZE-1:0] f_shift(input logic [SIZE-1:0] q, input logic md,
                                                 input logic b);
        return md ? {q[SIZE-2:0], b} : {b, q[SIZE-1:1]};
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_state      <= S_EMPTY;
            r_mode       <= 1'b1;
            r_q          <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    // Direction is latched on the first bit and frozen for the word
                    if (i_shift_en) begin
                        r_mode  <= i_left;
                        r_q     <= f_shift(r_q, i_left, i_sin);
                        r_count <= CNT_W'(1);
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (i_shift_en) begin
                        r_q <= f_shift(r_q, r_mode, i_sin);
                        if (r_count == CNT_W'(SIZE - 1)) begin
                            r_count <= CNT_W'(SIZE);
`ifdef LRSR_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_full  <= 1'b1;
                            r_state <= S_FULL;
`endif
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    // Parity bit is checked against the word but never shifted in
                    if (i_shift_en) begin
                        r_parity_err <= (^r_q) ^ i_sin;
                        r_full       <= 1'b1;
                        r_state      <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (i_rd) begin
                        r_full       <= 1'b0;
                        r_parity_err <= 1'b0;
                        if (i_shift_en) begin
                            r_mode  <= i_left;
                            r_q     <= f_shift(r_q, i_left, i_sin);
                            r_count <= CNT_W'(1);
                            r_state <= S_FILL;
                        end else begin
                            r_count <= '0;
                            r_state <= S_EMPTY;
                        end
                    end else if (i_shift_en) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign o_Q          = r_q;
    assign o_full       = r_full;
    assign o_bit_count  = r_count;
    assign o_overrun    = r_overrun;
    assign o_parity_err = r_parity_err;

endmodule

// File: doc/lr_deserial_sfr.md
Name: lr_deserial_sfr

Overview:
- Serial-in/parallel-out Special Function Register; the receive-side counterpart of the left/right shift SFR.
- Captures one bit per qualified clock, either MSB-first (shift left) or LSB-first (shift right), and assembles a SIZE-bit word.
- Presents the completed word with a full/read handshake to the consumer.
- Sits between a serial bit source and the register file / datapath bus.

Parameters:
- SIZE, 32, word width in bits (>= 2).
- CNT_W, $clog2(SIZE+1), width of bit_count.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear of word, count and flags.
- sin  input  1  serial data bit.
- shift_en  input  1  sin is valid this cycle; capture it.
- left  input  1  1 = MSB-first (shift left, sin enters bit 0); 0 = LSB-first (shift right, sin enters bit SIZE-1).
- rd  input  1  consumer acknowledges and releases the current full word.
- Q  output  SIZE  assembled word.
- full  output  1  Q holds a complete word.
- bit_count  output  CNT_W  bits captured into the current word, 0..SIZE.
- overrun  output  1  sticky: a bit arrived while full and was dropped.
- parity_err  output  1  parity check result (see Optional Feature).

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: Q=0, full=0, bit_count=0, overrun=0, parity_err=0, state=EMPTY, latched mode=left.
- Priority per edge: reset > clear > word-path logic. clear gives the same values as reset.
- States:
  - EMPTY: bit_count=0.
  - FILL: 0<bit_count<SIZE.
  - FULL: full=1.
- Direction latch:
  - `left` is sampled on the first bit of each word (EMPTY & shift_en) and held in an internal mode flop until the word completes.
  - Changes to `left` mid-word are ignored.
- Shift rules:
  - Mode left: Q <= {Q[SIZE-2:0], sin}.
  - Mode right: Q <= {sin, Q[SIZE-1:1]}.
- EMPTY & shift_en: shift, bit_count=1, go to FILL. For SIZE==1-style degenerate configurations, SIZE>=2 is required.
- FILL & shift_en: shift, bit_count+1. When bit_count reaches SIZE, go to FULL, with full=1 in the cycle after the SIZE-th capture edge.
- Latency: full rises exactly one clk after the edge sampling the last bit.
- FULL:
  - Q, bit_count(=SIZE) and mode are held; shift_en without rd drops the bit and sets overrun=1.
  - rd without shift_en: full=0, bit_count=0, go to EMPTY; Q keeps its last value until the next capture.
  - rd & shift_en on the same edge: the word is released and sin becomes bit 1 of the new word (bit_count=1, go to FILL). `left` is sampled for the new word. No overrun.
- rd outside FULL is ignored.
- overrun clears only on reset or clear.
- bit_count never wraps past SIZE.
- Reset or clear mid-word discards the partial word. The next shift_en starts a fresh word.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: LRSR_PARITY_EN.
- Defined:
  - After the SIZE data bits, FILL enters a PARITY state and expects one extra bit on the next shift_en. That bit is not shifted into Q.
  - Even parity: parity_err = ^Q ^ parity_bit, registered on the same edge that sets full.
  - parity_err holds until rd, reset or clear.
  - full rises one clk after the parity bit edge.
  - bit_count shows SIZE during PARITY.
- Undefined: no PARITY state; parity_err is tied 0.

Test Plan (SIZE=8):
- Reset, then 8 shift_en cycles, left=1, sin=1,0,1,1,0,0,1,0 -> Q=8'hB2, full=1 on the cycle after the 8th bit, bit_count=8, overrun=0.
- Same sin stream, left=0 -> Q=8'h4D. Toggling left after bit 3 has no effect (Q still 8'h4D).
- Full with 8'hB2; 2 more shift_en, no rd -> Q stays 8'hB2, overrun=1 sticky. Then rd -> full=0, bit_count=0. Overrun stays 1 until clear.
- Full with 8'hB2; rd & shift_en (sin=1, left=1) same edge -> full=0, bit_count=1, Q[0]=1, overrun=0. 7 more bits -> full again with no gap.
- Assert reset after 5 bits -> Q=0, bit_count=0, full=0 next cycle. Then 8 bits 8'hFF -> Q=8'hFF, full=1.
- LRSR_PARITY_EN defined: data 8'hB2 with parity bit 0 -> parity_err=0. With parity bit 1 -> parity_err=1. In both cases full rises one clk after the 9th bit.
